bloom_hash_arbiter: RTL

//  Shares one bloom-filter hash pipeline (data / data_valid / ready4_hash handshake, fixed stage

---
 rtl/bloom_hash_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/bloom_hash_arbiter.sv
// rtl/bloom_hash_arbiter.sv - round-robin share of one hash pipeline with a lockstep requester-tag pipe
// Optional per-requester grant and stall statistics are built when BLOOM_ARB_STATS_EN is defined.
module bloom_hash_arbiter #(
  parameter int DATA_WIDTH      = 128,
  parameter int NUM_REQ         = 4,
  parameter int REQ_ID_WIDTH    = 2,
  parameter int HASH_LATENCY    = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = 3
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            cfg_pause,
  output logic [DATA_WIDTH-1:0]           hash_data,
  output logic                            hash_data_vld,
  output logic                            hash_ready,
  input  logic                            hash_valid,
  input  logic                            dn_ready,
  output logic                            rsp_valid,
  output logic [REQ_ID_WIDTH-1:0]         rsp_id,
  output logic                            idle,
  output logic                            sync_err
`ifdef BLOOM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]           grant_cnt,
  output logic [31:0]                     stall_cnt
`endif
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

  logic [REQ_ID_WIDTH-1:0]                    rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0]                       cnt_q [NUM_REQ];
  logic [CNT_WIDTH-1:0]                       cnt_d [NUM_REQ];
  logic [HASH_LATENCY-1:0]                    tag_vld_q, tag_vld_d;
  logic [HASH_LATENCY-1:0][REQ_ID_WIDTH-1:0]  tag_id_q, tag_id_d;
  logic                                       sync_err_q, sync_err_d;

  logic [NUM_REQ-1:0]      elig;
  logic                    gnt_vld;
  logic [REQ_ID_WIDTH-1:0] gnt_id;
  logic                    rsp_take;
  logic                    underflow;
  logic                    cnt_zero;

  assign hash_ready = dn_ready;
  assign rsp_valid  = hash_valid;
  assign rsp_id     = tag_id_q[HASH_LATENCY-1];
  assign rsp_take   = hash_valid & dn_ready;
  assign sync_err   = sync_err_q;

  // A slot being returned this cycle counts as free, so a capped requester regrants without a bubble.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = rstb && req_valid[i] && !cfg_pause && dn_ready &&
                ((cnt_q[i] < MAX_CNT) || (rsp_take && (rsp_id == REQ_ID_WIDTH'(i))));
    end
  end

  always_comb begin : arb
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = REQ_ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    req_ready     = '0;
    hash_data_vld = gnt_vld;
    hash_data     = '0;
    if (gnt_vld) begin
      req_ready[gnt_id] = 1'b1;
      hash_data         = req_data[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    tag_vld_d  = tag_vld_q;
    tag_id_d   = tag_id_q;
    underflow  = 1'b0;
    cnt_zero   = 1'b1;
    if (gnt_vld) begin
      rr_ptr_d = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + REQ_ID_WIDTH'(1);
    end
    if (dn_ready) begin
      tag_vld_d = {tag_vld_q[HASH_LATENCY-2:0], gnt_vld};
      tag_id_d  = {tag_id_q[HASH_LATENCY-2:0], gnt_id};
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_q[i] != '0) cnt_zero = 1'b0;
      if (gnt_vld && (gnt_id == REQ_ID_WIDTH'(i)) && !(rsp_take && (rsp_id == REQ_ID_WIDTH'(i)))) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end else if (rsp_take && (rsp_id == REQ_ID_WIDTH'(i)) && !(gnt_vld && (gnt_id == REQ_ID_WIDTH'(i)))) begin
        if (cnt_q[i] == '0) underflow = 1'b1;
        else cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
      end
    end
    sync_err_d = sync_err_q | underflow | (dn_ready && (hash_valid != tag_vld_q[HASH_LATENCY-1]));
  end

  assign idle = !gnt_vld && (tag_vld_q == '0) && cnt_zero;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rr_ptr_q   <= '0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      sync_err_q <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
      sync_err_q <= sync_err_d;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef BLOOM_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] grant_cnt_q;
  logic [31:0]              stall_cnt_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && (grant_cnt_q[i] != 32'hffff_ffff)) begin
          grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
        end
      end
      if ((|req_valid) && !gnt_vld && (stall_cnt_q != 32'hffff_ffff)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
